// File: rtl/node.sv
// node: fixed-point MAC neuron, saturating ACC_W accumulator, optional NODE_RELU_EN output clamp.
// Latency: one cycle; a start-cycle product is visible on node_out after the next rising edge.
// Backpressure: none, so every start cycle accumulates; reset_acc overrides start.
module node #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int NUM_IN   = 64,
    parameter int NUM_COEF = 16,
    parameter int CNT_W    = 7,
    parameter int ACC_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     reset_acc,
    input  logic [CNT_W-1:0]         cnt_val,
    input  logic signed [DATA_W-1:0] coef    [NUM_COEF],
    input  logic signed [DATA_W-1:0] data_in [NUM_IN],
    output logic signed [DATA_W-1:0] node_out
);
    localparam int IN_IDX_W   = $clog2(NUM_IN);
    localparam int COEF_IDX_W = $clog2(NUM_COEF);
    localparam int PROD_W     = 2 * DATA_W;
    localparam int SHF_W      = PROD_W - FRAC_W;

    localparam logic [CNT_W:0]         NUM_IN_L = (CNT_W + 1)'(NUM_IN);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    logic [IN_IDX_W-1:0]        in_idx;
    logic [COEF_IDX_W-1:0]      coef_idx;
    logic                       in_range;
    logic signed [DATA_W-1:0]   sample;
    logic signed [DATA_W-1:0]   weight;
    logic signed [PROD_W-1:0]   prod_full;
    logic signed [SHF_W-1:0]    prod_shf;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W:0]      sum_wide;
    logic signed [ACC_W-1:0]    sum_sat;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_nxt;
    logic [ACC_W-DATA_W:0]      acc_hi;
    logic signed [DATA_W-1:0]   out_sat;

    // Coefficients alias onto the low index bits; out-of-range samples contribute zero.
    assign in_idx   = cnt_val[IN_IDX_W-1:0];
    assign coef_idx = cnt_val[COEF_IDX_W-1:0];
    assign in_range = ({1'b0, cnt_val} < NUM_IN_L);

    assign sample = in_range ? data_in[in_idx] : '0;
    assign weight = coef[coef_idx];

    assign prod_full = sample * weight;
    assign prod_shf  = SHF_W'(prod_full >>> FRAC_W);
    assign prod_ext  = ACC_W'(prod_shf);

    // One guard bit detects signed overflow of the accumulate.
    assign sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};

    always_comb begin
        sum_sat = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        acc_nxt = acc;
        if (reset_acc) begin
            acc_nxt = '0;
        end else if (start && in_range) begin
            acc_nxt = sum_sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc_nxt;
        end
    end

    // acc fits DATA_W when every bit above the output sign bit matches it.
    assign acc_hi = acc[ACC_W-1:DATA_W-1];

    always_comb begin
        out_sat = acc[DATA_W-1:0];
        if (!((&acc_hi) || !(|acc_hi))) begin
            out_sat = acc[ACC_W-1] ? OUT_MIN : OUT_MAX;
        end
    end

`ifdef NODE_RELU_EN
    assign node_out = out_sat[DATA_W-1] ? '0 : out_sat;
`else
    assign node_out = out_sat;
`endif

endmodule

// File: tb/tb_node.sv
// Scoreboard bench for node: expected outputs queued as stimulus is applied, checked after the edge.
module tb_node;
    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               reset_acc;
    logic [6:0]         cnt_val;
    logic signed [15:0] coef    [16];
    logic signed [15:0] data_in [64];
    logic signed [15:0] node_out;

    longint     m_acc;
    logic [15:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [15:0] neg_exp;

    node dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reset_acc (reset_acc),
        .cnt_val   (cnt_val),
        .coef      (coef),
        .data_in   (data_in),
        .node_out  (node_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: node_out=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_out(input longint a);
        longint v;
        v = a;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`ifdef NODE_RELU_EN
        if (v < 0) v = 0;
`endif
        return 16'(v);
    endfunction

    // Advance the reference model for the inputs now applied, then check after the edge.
    task automatic step(input string tag);
        longint p;
        if (rst || reset_acc) begin
            m_acc = 0;
        end else if (start && cnt_val < 7'd64) begin
            p = (longint'(data_in[cnt_val[5:0]]) * longint'(coef[cnt_val[3:0]])) >>> 8;
            m_acc = m_acc + p;
            if (m_acc > 64'sd2147483647) m_acc = 64'sd2147483647;
            if (m_acc < -64'sd2147483648) m_acc = -64'sd2147483648;
        end
        exp_q.push_back(model_out(m_acc));
        @(posedge clk);
        @(negedge clk);
        check_val(tag, node_out, exp_q.pop_front());
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; reset_acc = 1'b0; cnt_val = '0;
        m_acc = 0;
        for (int i = 0; i < 16; i++) coef[i] = '0;
        for (int i = 0; i < 64; i++) data_in[i] = '0;
`ifdef NODE_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'h8000;
`endif
        @(negedge clk);
        check_val("rst_init", node_out, 16'h0000);
        run("rst_hold", 5);
        rst = 1'b0;

        data_in[0] = 16'h0001;
        run("idle", 5);
        check_val("idle_end", node_out, 16'h0000);

        cnt_val = 7'd1; data_in[1] = 16'h0400; coef[1] = 16'h0100; start = 1'b1;
        step("acc1");
        check_val("acc_c1", node_out, 16'h0400);
        run("acc", 4);
        check_val("acc_c5", node_out, 16'h1400);
        start = 1'b0;
        run("hold", 5);
        check_val("hold_end", node_out, 16'h1400);

        reset_acc = 1'b1; start = 1'b1;
        step("clr_prio");
        check_val("clr_prio_c", node_out, 16'h0000);
        reset_acc = 1'b0;
        step("resume");
        check_val("resume_c", node_out, 16'h0400);

        run("pre_rst", 2);
        #2 rst = 1'b1;
        #1 check_val("async_rst", node_out, 16'h0000);
        step("rst_mid");
        rst = 1'b0; start = 1'b0;
        step("post_rst");

        cnt_val = 7'd2; data_in[2] = 16'h7FFF; coef[2] = 16'h7FFF; start = 1'b1;
        run("sat_pos", 4);
        check_val("sat_pos_c", node_out, 16'h7FFF);
        coef[2] = 16'h8000;
        run("sat_neg", 8);
        check_val("sat_neg_c", node_out, neg_exp);

        start = 1'b0; reset_acc = 1'b1;
        step("clr");
        reset_acc = 1'b0;
        cnt_val = 7'd3; data_in[3] = 16'hFFFF; coef[3] = 16'h0001; start = 1'b1;
        step("trunc");
`ifdef NODE_RELU_EN
        check_val("trunc_c", node_out, 16'h0000);
`else
        check_val("trunc_c", node_out, 16'hFFFF);
`endif

        start = 1'b0; reset_acc = 1'b1;
        step("clr");
        reset_acc = 1'b0;
        cnt_val = 7'd17; data_in[17] = 16'h0200; coef[1] = 16'h0100; start = 1'b1;
        step("alias");
        check_val("alias_c", node_out, 16'h0200);
        cnt_val = 7'd64; data_in[0] = 16'h0100; coef[0] = 16'h0100;
        step("oor64");
        check_val("oor64_c", node_out, 16'h0200);
        cnt_val = 7'd127;
        step("oor127");
        check_val("oor127_c", node_out, 16'h0200);

        start = 1'b0; reset_acc = 1'b1;
        step("clr");
        reset_acc = 1'b0;
        cnt_val = 7'd4; data_in[4] = 16'h8000; coef[4] = 16'h8000; start = 1'b1;
        run("accsat_up", 600);
        check_val("accsat_up_c", node_out, 16'h7FFF);
        coef[4] = 16'h7FFF;
        run("accsat_down", 520);

        for (int i = 0; i < 80; i++) begin
            cnt_val = 7'($urandom_range(0, 127));
            data_in[cnt_val[5:0]] = 16'($urandom);
            coef[cnt_val[3:0]] = 16'($urandom);
            start = 1'($urandom_range(0, 3) != 0);
            reset_acc = 1'($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
